// File: rtl/my_cpu_trap_pc.sv
// PC register and machine-mode trap sequencer (RUN/HANDLER/LOCKUP).
// Optional trap counter output enabled by defining TRAP_COUNTER_EN.
module my_cpu_trap_pc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] MTVEC_BASE = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  IntCause,
  input  logic        MRet,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_next,
  output logic [31:0] pc_out,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic        mie,
  output logic        in_handler,
  output logic        trap_taken,
  output logic        ext_ack,
`ifdef TRAP_COUNTER_EN
  output logic [31:0] trap_count,
`endif
  output logic        lockup
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    LOCKUP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        mie_q, mie_d;
  logic        trap_q, trap_d;
  logic        ext_q, ext_d;
  logic        take;
  logic        dbl;
  logic [1:0]  code;
  logic        sync_c;

  assign sync_c = (IntCause == 2'd1) || (IntCause == 2'd2);

  // Next-state decode: trap entry, mret return, double fault, fetch advance
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mie_d    = mie_q;
    trap_d   = 1'b0;
    ext_d    = 1'b0;
    take     = 1'b0;
    dbl      = 1'b0;
    code     = 2'd0;
    if (en && state_q != LOCKUP) begin
      pc_d = pc_next;
      if (state_q == RUN) begin
        if (sync_c) begin
          take     = 1'b1;
          code     = IntCause;
          mepc_d   = pc_cur;
          mcause_d = (IntCause == 2'd1) ? 32'd2 : 32'd11;
        end else if (IntCause == 2'd3) begin
          if (mie_q) begin
            take     = 1'b1;
            code     = 2'd3;
            mepc_d   = pc_next;
            mcause_d = 32'h8000_000B;
            ext_d    = 1'b1;
          end
        end else if (MRet) begin
          take     = 1'b1;
          code     = 2'd1;
          mepc_d   = pc_cur;
          mcause_d = 32'd2;
        end
      end else begin
        if (sync_c) begin
          dbl     = 1'b1;
          state_d = LOCKUP;
          pc_d    = pc_q;
        end else if (MRet) begin
          pc_d    = mepc_q;
          mie_d   = 1'b1;
          state_d = RUN;
        end
      end
      if (take) begin
        pc_d    = MTVEC_BASE + {28'd0, code, 2'b00};
        mie_d   = 1'b0;
        trap_d  = 1'b1;
        state_d = HANDLER;
      end
    end
  end

  // State and architectural registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
      mie_q    <= 1'b1;
      trap_q   <= 1'b0;
      ext_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mie_q    <= mie_d;
      trap_q   <= trap_d;
      ext_q    <= ext_d;
    end
  end

`ifdef TRAP_COUNTER_EN
  logic [31:0] cnt_q, cnt_d;

  // Saturating count of taken traps and double faults
  always_comb begin
    cnt_d = cnt_q;
    if ((take || dbl) && cnt_q != 32'hFFFF_FFFF)
      cnt_d = cnt_q + 32'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= 32'd0;
    else      cnt_q <= cnt_d;
  end

  assign trap_count = cnt_q;
`endif

  assign pc_out     = pc_q;
  assign mepc       = mepc_q;
  assign mcause     = mcause_q;
  assign mie        = mie_q;
  assign in_handler = (state_q == HANDLER);
  assign lockup     = (state_q == LOCKUP);
  assign trap_taken = trap_q;
  assign ext_ack    = ext_q;

endmodule

// File: doc/my_cpu_trap_pc.md
Name: my_cpu_trap_pc

Overview:
- PC register plus machine-mode trap sequencer. Sits directly downstream of the control unit.
- Consumes IntCause and MRet together with the datapath's computed next PC, and decides each cycle the PC fetched next.
- Holds mepc, mcause and the MIE flag, and tracks whether the core is inside a trap handler.
- Lockup is entered on a double fault; only reset leaves it.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MTVEC_BASE, 32'h0000_0004, base of the vectored handler table; handler address = MTVEC_BASE + {cause, 2'b00}.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset: sampled at the rising edge, low resets.
- en  in  1  instruction retires this cycle; low = stall, all state held.
- IntCause  in  2  from control: 0 none, 1 illegal, 2 ecall, 3 external.
- MRet  in  1  from control: current instruction is mret.
- pc_cur  in  32  PC of the current instruction.
- pc_next  in  32  datapath next PC (pc+4, branch or jump target).
- pc_out  out  32  PC register, drives instruction fetch.
- mepc  out  32  saved return PC.
- mcause  out  32  last trap cause.
- mie  out  1  machine interrupt enable.
- in_handler  out  1  high while state is HANDLER.
- trap_taken  out  1  one-cycle pulse after a trap is taken.
- ext_ack  out  1  one-cycle pulse after an external interrupt is taken.
- lockup  out  1  high in LOCKUP.

Behaviour:
- Reset: pc_out=RESET_PC, mepc=0, mcause=0, mie=1, state RUN. in_handler, trap_taken, ext_ack and lockup are all 0. Reset overrides en and every other input.
- Every update happens at a rising edge with en=1. With en=0: pc_out, mepc, mcause, mie and state hold; trap_taken and ext_ack are 0.
- Pulse timing: trap_taken and ext_ack are registered, high exactly the one cycle following the edge that took the trap.
- States: RUN, HANDLER, LOCKUP. in_handler = (state==HANDLER); lockup = (state==LOCKUP).
- RUN, evaluated in priority order:
  - IntCause 1 or 2: take a synchronous trap. mepc<=pc_cur; mcause<=32'd2 (illegal) or 32'd11 (ecall).
  - IntCause 3 with mie=1: take an external trap. mepc<=pc_next (resume after the instruction); mcause<=32'h8000_000B; ext_ack pulses.
  - IntCause 3 with mie=0: ignored, pc_out<=pc_next. Because control's cause 3 overrides its own cause, a masked external also hides that instruction's synchronous cause; this is accepted behaviour.
  - MRet: mret outside a handler is an illegal trap. mcause<=2, mepc<=pc_cur.
  - Otherwise: pc_out<=pc_next.
- Any trap taken: pc_out<=MTVEC_BASE+{cause,2'b00}; mie<=0; trap_taken pulses; state->HANDLER.
- HANDLER:
  - IntCause 1 or 2 is a double fault. State->LOCKUP; pc_out, mepc and mcause are frozen.
  - MRet returns: pc_out<=mepc, mie<=1, state->RUN. MRet wins over a simultaneous IntCause 3.
  - With MRet, the external interrupt is taken at the next retiring cycle if IntCause is still 3.
  - IntCause 3 without MRet: ignored, pc_out<=pc_next.
  - Otherwise pc_out<=pc_next.
- LOCKUP: all registers hold, en is ignored, and only reset exits.
- Width rules:
  - Adder is 32-bit and wraps modulo 2^32.
  - pc_next passes through unmodified, including bits [1:0].
  - mepc is stored as a full 32-bit value.
- Reset mid-handler: the state is discarded and mie returns to 1.

Optional Feature:
- Macro: TRAP_COUNTER_EN.
- Defined:
  - Adds output trap_count[31:0], reset 0.
  - Increments by 1 on each taken trap (same edge as state->HANDLER) and saturates at 32'hFFFF_FFFF.
  - A double fault into LOCKUP also increments it.
  - It holds when en=0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset then straight-line code: rst low 1 cycle then high; pc_next=pc+4 each cycle, IntCause=0 -> pc_out 0,4,8,...; mie=1; in_handler=0.
- Ecall: pc_cur=0x40, IntCause=2, en=1 -> next cycle pc_out=0x0C, mepc=0x40, mcause=11, mie=0, trap_taken=1 for one cycle. Then MRet -> pc_out=0x40, mie=1, state RUN.
- External interrupt: pc_cur=0x80, pc_next=0x100, IntCause=3, mie=1 -> pc_out=0x10, mepc=0x100, mcause=0x8000000B, ext_ack pulse. A second IntCause=3 while in the handler -> ignored, pc_out=pc_next.
- Masking and stall:
  - IntCause=3 held with en=0 for 3 cycles -> no change, no pulses.
  - MRet and IntCause=3 together in the handler -> pc_out=mepc and mie=1, then the trap is taken on the next en cycle.
- Double fault and illegal mret:
  - IntCause=1 while in the handler -> lockup=1, pc_out frozen across 5 cycles, cleared only by rst low.
  - MRet in RUN at pc_cur=0x20 -> mcause=2, mepc=0x20, pc_out=0x08.
